// File: rtl/w_sched_ctrl.sv
// Issue controller for the SHA-256 W-schedule chain: spaces first-stage
// enables, tags in-flight blocks with their nonce, and flushes on abort.
module w_sched_ctrl #(
    parameter int DELAY        = 4,
    parameter int N_STAGES     = 12,
    parameter int MAX_INFLIGHT = 16,
    parameter int TAG_W        = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          blk_valid,
    input  logic [TAG_W-1:0]              blk_nonce,
    output logic                          blk_ready,
    output logic                          w_en,
    input  logic                          w_done,
    output logic                          out_valid,
    output logic [TAG_W-1:0]              out_nonce,
    input  logic                          abort,
    output logic                          drain_done,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          tag_err,
    output logic                          busy
);

    localparam int PW = $clog2(MAX_INFLIGHT);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(DELAY + 1);

    if (MAX_INFLIGHT < N_STAGES + 1 ||
        (MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0) begin : g_bad_cfg
        $error("w_sched_ctrl: MAX_INFLIGHT must be a power of two >= N_STAGES+1");
    end

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        DRAIN
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [GW-1:0]     gap_cnt;
    logic [GW-1:0]     gap_d;
    logic              abort_pend;

    logic [TAG_W-1:0]  tag_mem [MAX_INFLIGHT];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic              accept;
    logic              pop;
    logic              fifo_empty;
    logic              drain_exit;

    assign fifo_empty = (count == '0);
    assign pop        = w_done && !fifo_empty;
    assign blk_ready  = !reset && (state == IDLE) && !abort_pend &&
                        (count < CW'(MAX_INFLIGHT));
    assign accept     = blk_valid && blk_ready;
    assign drain_exit = (state == DRAIN) && fifo_empty && !w_done;
    assign drain_done = drain_exit;
    assign inflight   = count;
    assign busy       = (state != IDLE) || !fifo_empty;

    always_comb begin
        state_d = state;
        gap_d   = gap_cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_d = GAP;
                    gap_d   = GW'(DELAY - 1);
                end else if (abort_pend) begin
                    state_d = DRAIN;
                end
            end
            GAP: begin
                // Last gap cycle hands straight to DRAIN if a flush is queued
                if (gap_cnt <= GW'(1)) begin
                    state_d = abort_pend ? DRAIN : IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d   = gap_cnt - GW'(1);
                end
            end
            DRAIN: begin
                if (drain_exit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[wr_ptr] <= blk_nonce;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            abort_pend <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            w_en       <= 1'b0;
            out_valid  <= 1'b0;
            out_nonce  <= '0;
            tag_err    <= 1'b0;
        end else begin
            state   <= state_d;
            gap_cnt <= gap_d;
            w_en    <= accept;

            if (drain_exit) begin
                abort_pend <= 1'b0;
            end else if (abort && state != DRAIN) begin
                abort_pend <= 1'b1;
            end

            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end

            unique case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Tags popped while draining are discarded silently
            out_valid <= pop && (state != DRAIN);
            if (pop && state != DRAIN) begin
                out_nonce <= tag_mem[rd_ptr];
            end

            if (w_done && fifo_empty) begin
                tag_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_w_sched_ctrl.sv
// Directed bench for w_sched_ctrl: issue spacing, tag order, full,
// same-cycle accept/pop, abort flush and tag underflow.
module tb_w_sched_ctrl;

    localparam int DELAY = 4;
    localparam int NST   = 3;
    localparam int MAXI  = 4;
    localparam int TW    = 32;
    localparam int LAT   = 48;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          blk_valid = 1'b0;
    logic [TW-1:0] blk_nonce = '0;
    logic          blk_ready;
    logic          w_en;
    logic          w_done;
    logic          out_valid;
    logic [TW-1:0] out_nonce;
    logic          abort = 1'b0;
    logic          drain_done;
    logic [2:0]    inflight;
    logic          tag_err;
    logic          busy;

    logic man_done = 1'b0;
    logic chain_done = 1'b0;
    logic chain_on = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int due_q[$];
    int wen_cyc[3];
    int nw;
    int n_out;
    int nacc;
    logic acc;

    assign w_done = man_done | chain_done;

    w_sched_ctrl #(
        .DELAY(DELAY),
        .N_STAGES(NST),
        .MAX_INFLIGHT(MAXI),
        .TAG_W(TW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .blk_valid(blk_valid),
        .blk_nonce(blk_nonce),
        .blk_ready(blk_ready),
        .w_en(w_en),
        .w_done(w_done),
        .out_valid(out_valid),
        .out_nonce(out_nonce),
        .abort(abort),
        .drain_done(drain_done),
        .inflight(inflight),
        .tag_err(tag_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Fixed-latency chain model: w_done LAT cycles after each w_en
    always @(negedge clk) begin
        chain_done = 1'b0;
        if (!chain_on) begin
            due_q.delete();
        end else begin
            if (w_en) due_q.push_back(cyc + LAT);
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                chain_done = 1'b1;
                void'(due_q.pop_front());
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_done();
        man_done = 1'b1;
        step();
        man_done = 1'b0;
    endtask

    task automatic push_blk(input logic [31:0] n);
        blk_nonce = n;
        blk_valid = 1'b1;
        for (int i = 0; i < 20 && !blk_ready; i++) step();
        check("push_rdy", blk_ready, 1);
        step();
        blk_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        check("rst_rdy", blk_ready, 0);
        check("rst_wen", w_en, 0);
        check("rst_ov", out_valid, 0);
        check("rst_nonce", out_nonce, 0);
        check("rst_infl", inflight, 0);
        check("rst_terr", tag_err, 0);
        check("rst_busy", busy, 0);
        check("rst_dd", drain_done, 0);

        // Back-to-back offers: enables every DELAY cycles
        chain_on  = 1'b1;
        reset     = 1'b0;
        blk_valid = 1'b1;
        blk_nonce = 0;
        nw        = 0;
        #1;
        for (int c = 0; c <= 12; c++) begin
            check($sformatf("rdy@%0d", c), blk_ready, (c % 4) == 0);
            check($sformatf("wen@%0d", c), w_en, c == 1 || c == 5 || c == 9);
            if (w_en && nw < 3) begin
                wen_cyc[nw] = cyc;
                nw++;
            end
            acc = blk_valid && blk_ready;
            step();
            if (acc) begin
                blk_nonce++;
                if (blk_nonce == 3) blk_valid = 1'b0;
            end
        end
        check("t1_infl", inflight, 3);
        check("t1_nw", nw, 3);

        n_out = 0;
        for (int i = 0; i < 120 && n_out < 3; i++) begin
            step();
            if (out_valid) begin
                check($sformatf("t1_nonce%0d", n_out), out_nonce, n_out);
                check($sformatf("t1_lat%0d", n_out), cyc - wen_cyc[n_out], LAT + 1);
                n_out++;
            end
        end
        check("t1_nout", n_out, 3);
        step();
        check("t1_infl0", inflight, 0);
        check("t1_busy0", busy, 0);
        chain_on = 1'b0;

        // Fill to MAX_INFLIGHT with completions held off
        blk_nonce = 32'h10;
        blk_valid = 1'b1;
        nacc      = 0;
        for (int i = 0; i < 24; i++) begin
            acc = blk_valid && blk_ready;
            step();
            if (acc) begin
                nacc++;
                blk_nonce++;
            end
        end
        check("t2_nacc", nacc, 4);
        check("t2_rdy0", blk_ready, 0);
        check("t2_infl", inflight, 4);
        check("t2_busy", busy, 1);
        pulse_done();
        check("t2_ov", out_valid, 1);
        check("t2_nonce", out_nonce, 32'h10);
        check("t2_rdy1", blk_ready, 1);
        check("t2_infl3", inflight, 3);
        step();
        blk_valid = 1'b0;
        blk_nonce = 32'h15;
        check("t2_wen", w_en, 1);
        check("t2_infl4", inflight, 4);
        check("t2_rdygap", blk_ready, 0);

        // Same-cycle accept and completion at inflight==2
        repeat (4) step();
        pulse_done();
        check("t3_nonce11", out_nonce, 32'h11);
        step();
        pulse_done();
        check("t3_nonce12", out_nonce, 32'h12);
        check("t3_infl2", inflight, 2);
        blk_valid = 1'b1;
        man_done  = 1'b1;
        check("t3_rdy", blk_ready, 1);
        step();
        blk_valid = 1'b0;
        man_done  = 1'b0;
        check("t3_inflsame", inflight, 2);
        check("t3_ov", out_valid, 1);
        check("t3_nonce13", out_nonce, 32'h13);
        check("t3_wen", w_en, 1);
        pulse_done();
        check("t3_nonce14", out_nonce, 32'h14);
        pulse_done();
        check("t3_nonce15", out_nonce, 32'h15);
        check("t3_infl0", inflight, 0);

        // Abort with three blocks in flight
        step();
        push_blk(32'h20);
        push_blk(32'h21);
        push_blk(32'h22);
        repeat (4) step();
        check("t4_infl3", inflight, 3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_rdy_pend", blk_ready, 0);
        check("t4_busy", busy, 1);
        step();
        check("t4_rdy_drain", blk_ready, 0);
        pulse_done();
        check("t4_ov1", out_valid, 0);
        check("t4_dd1", drain_done, 0);
        pulse_done();
        check("t4_ov2", out_valid, 0);
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        #1;
        check("t4_ov3", out_valid, 0);
        check("t4_dd", drain_done, 1);
        check("t4_infl0", inflight, 0);
        step();
        check("t4_dd_off", drain_done, 0);
        check("t4_rdy1", blk_ready, 1);
        check("t4_busy0", busy, 0);

        // Completion with no tag outstanding
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        pulse_done();
        check("t5_terr", tag_err, 1);
        check("t5_ov", out_valid, 0);
        check("t5_infl", inflight, 0);
        push_blk(32'h30);
        pulse_done();
        check("t5_ov2", out_valid, 1);
        check("t5_nonce", out_nonce, 32'h30);
        check("t5_terr_stk", tag_err, 1);
        reset = 1'b1;
        step();
        check("t5_terr_rst", tag_err, 0);
        check("t5_nonce_rst", out_nonce, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/w_sched_ctrl.md
Name: w_sched_ctrl

Overview:
- Issue controller for the SHA-256 message-schedule expansion chain: N_STAGES cascaded W stages, each producing DELAY new words per enable.
- Admits 512-bit block jobs from the nonce generator and spaces the first-stage enables so no stage is re-enabled mid-computation.
- Tags every in-flight block with its nonce and re-associates the tag with the chain's completion pulse.
- Supports a host abort that flushes in-flight work before new jobs are accepted.

Parameters:
- DELAY, 4: words per W stage; minimum cycles between first-stage enables.
- N_STAGES, 12: W stages in the chain, (64-16)/DELAY.
- MAX_INFLIGHT, 16: tag FIFO depth. Must be >= N_STAGES+1. Power of two.
- TAG_W, 32: nonce tag width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- blk_valid  in  1  upstream block + nonce valid
- blk_nonce  in  TAG_W  nonce of offered block
- blk_ready  out  1  controller can accept
- w_en  out  1  single-cycle enable to first W stage (also loads Win register)
- w_done  in  1  en_next of last W stage
- out_valid  out  1  completed-block strobe (no backpressure)
- out_nonce  out  TAG_W  nonce of completed block
- abort  in  1  flush request
- drain_done  out  1  one-cycle pulse, flush complete
- inflight  out  $clog2(MAX_INFLIGHT)+1  blocks issued, not yet done
- tag_err  out  1  sticky: w_done with empty tag FIFO
- busy  out  1  state!=IDLE or inflight!=0

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: every output 0, state IDLE, tag FIFO empty, gap counter 0, abort_pend 0.
- Reset mid-operation discards all tags. In-flight blocks are lost.
- States:
  - IDLE: blk_ready = (inflight < MAX_INFLIGHT) and not abort_pend.
    - On blk_valid&&blk_ready (accept), push blk_nonce into the FIFO, go to GAP, gap counter = DELAY-1.
    - With no accept: abort_pend moves to DRAIN.
  - GAP: blk_ready=0. Gap counter decrements each cycle. At 1, go to IDLE (or DRAIN if abort_pend).
  - DRAIN: blk_ready=0. out_valid suppressed; w_done still pops tags. When inflight==0 and w_done==0, go to IDLE, pulse drain_done and clear abort_pend.
- w_en timing: w_en=1 exactly one cycle, the cycle after accept. Consecutive w_en pulses are therefore >= DELAY cycles apart.
- Completion: w_done with a non-empty FIFO pops the head. In IDLE/GAP, the next cycle gives out_valid=1 for one cycle and out_nonce = popped tag. out_nonce holds its last value otherwise.
- Underflow: w_done with an empty FIFO sets tag_err (sticky until reset). No pop, no out_valid.
- inflight: +1 on accept, -1 on valid pop. An accept and a pop in the same cycle leave it unchanged. It equals the FIFO occupancy.
- Full: at inflight==MAX_INFLIGHT, blk_ready=0. It reasserts the cycle after a pop.
- abort:
  - Sets abort_pend on any cycle.
  - abort in DRAIN is ignored.
  - abort coincident with an accept: the accept completes (w_en issued), then the flush covers that block.
  - abort with inflight==0 in IDLE: one DRAIN cycle, then drain_done.
- Ordering: the chain is in-order and fixed-latency, so tags pop FIFO-order. Expected w_done latency is N_STAGES*DELAY cycles after w_en, but the controller does not depend on it.
- FIFO pointers: log2(MAX_INFLIGHT) bits, wrap modulo depth.

Test Plan:
- Reset, then blk_valid=1 continuously with nonces 0x0,0x1,0x2 -> w_en pulses at cycles 1, 5, 9 (DELAY=4), blk_ready low 3 cycles after each accept, inflight reaches 3.
- Chain model returns w_done 48 cycles after each w_en -> out_valid one cycle later with out_nonce 0x0,0x1,0x2 in order, inflight back to 0, busy falls.
- MAX_INFLIGHT=4, w_done held off, 6 offered blocks -> exactly 4 accepted, blk_ready stays 0. First w_done -> blk_ready=1 next IDLE cycle, 5th accepted, inflight stays 4.
- Accept and w_done in the same cycle with inflight=2 -> inflight remains 2, out_nonce = oldest tag, new tag queued at tail.
- abort with 3 blocks in flight -> blk_ready=0, no out_valid for those 3 w_done pulses, drain_done one cycle after last w_done, then blk_ready=1.
- Inject w_done after reset with empty FIFO -> tag_err=1, out_valid=0. Subsequent normal traffic unaffected, tag_err stays 1 until reset.
